// File: rtl/top_vga_pong.sv
`default_nettype none
// ============================================================================
// Module   : top_vga_pong
// Purpose  : Two-player pong on 640x480@60 VGA timing, one pixel per clock.
// Revision : 1.0
// ============================================================================
module top_vga_pong #(
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PAD_H    = 80,
    parameter int PAD_STEP = 4,
    parameter int BALL_SZ  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sw,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p2_up,
    input  logic       p2_down,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb
);

    localparam logic [10:0] c_H_LAST   = 11'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] c_V_LAST   = 11'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] c_H_VIS    = 11'(H_VIS);
    localparam logic [10:0] c_V_VIS    = 11'(V_VIS);
    localparam logic [10:0] c_HS_BEG   = 11'(H_VIS + H_FP);
    localparam logic [10:0] c_HS_END   = 11'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [10:0] c_VS_BEG   = 11'(V_VIS + V_FP);
    localparam logic [10:0] c_VS_END   = 11'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [10:0] c_PAD_H    = 11'(PAD_H);
    localparam logic [10:0] c_PAD_W    = 11'd8;
    localparam logic [10:0] c_STEP     = 11'(PAD_STEP);
    localparam logic [10:0] c_PAD_MAX  = 11'(V_VIS - PAD_H);
    localparam logic [10:0] c_PAD_INIT = 11'((V_VIS - PAD_H) / 2);
    localparam logic [10:0] c_BALL     = 11'(BALL_SZ);
    localparam logic [10:0] c_BX0      = 11'(H_VIS / 2 - BALL_SZ / 2);
    localparam logic [10:0] c_BY0      = 11'(V_VIS / 2 - BALL_SZ / 2);
    localparam logic [10:0] c_BX_MAX   = 11'(H_VIS - BALL_SZ);
    localparam logic [10:0] c_BY_MAX   = 11'(V_VIS - BALL_SZ);
    localparam logic [10:0] c_P1_X     = 11'd16;
    localparam logic [10:0] c_P2_X     = 11'(H_VIS - 24);

    logic [10:0] r_h, r_v;
    logic [10:0] r_p1_y, r_p2_y, r_bx, r_by;
    logic        r_dx, r_dy;
    logic        r_hsync, r_vsync;
    logic [2:0]  r_rgb;

    logic [10:0] w_s, w_bx_nxt, w_by_nxt;
    logic        w_dx_nxt, w_dy_nxt, w_miss;
    logic        w_tick, w_ov1, w_ov2, w_vis, w_ball_px, w_pad_px;
    logic [2:0]  w_pix, w_rgb;

    function automatic logic [10:0] paddle_next(input logic [10:0] y,
                                                input logic up, input logic dn);
        logic [10:0] n;
        n = y;
        if (up && !dn)
            n = (y <= c_STEP) ? 11'd0 : y - c_STEP;
        else if (dn && !up)
            n = (y >= c_PAD_MAX - c_STEP) ? c_PAD_MAX : y + c_STEP;
        return n;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == c_H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == c_V_LAST) ? 11'd0 : r_v + 11'd1;
        end else begin
            r_h <= r_h + 11'd1;
        end
    end

    assign w_tick = (r_h == 11'd0) && (r_v == c_V_VIS);
    assign w_s    = sw[2] ? 11'd4 : 11'd2;
    assign w_ov1  = (r_by + c_BALL > r_p1_y) && (r_by < r_p1_y + c_PAD_H);
    assign w_ov2  = (r_by + c_BALL > r_p2_y) && (r_by < r_p2_y + c_PAD_H);

    // dx/dy: 1 = right/down. A miss overrides both axes.
    always_comb begin
        w_bx_nxt = r_bx;
        w_by_nxt = r_by;
        w_dx_nxt = r_dx;
        w_dy_nxt = r_dy;
        w_miss   = 1'b0;
        if (!r_dy) begin
            if (r_by <= w_s) begin
                w_by_nxt = 11'd0;
                w_dy_nxt = 1'b1;
            end else begin
                w_by_nxt = r_by - w_s;
            end
        end else if (r_by >= c_BY_MAX - w_s) begin
            w_by_nxt = c_BY_MAX;
            w_dy_nxt = 1'b0;
        end else begin
            w_by_nxt = r_by + w_s;
        end
        if (!r_dx) begin
            if (r_bx <= c_P1_X + c_PAD_W && r_bx >= c_P1_X && w_ov1) begin
                w_bx_nxt = c_P1_X + c_PAD_W;
                w_dx_nxt = 1'b1;
            end else if (r_bx <= w_s) begin
                w_miss = 1'b1;
            end else begin
                w_bx_nxt = r_bx - w_s;
            end
        end else begin
            if (r_bx + c_BALL >= c_P2_X && r_bx + c_BALL <= c_P2_X + c_PAD_W && w_ov2) begin
                w_bx_nxt = c_P2_X - c_BALL;
                w_dx_nxt = 1'b0;
            end else if (r_bx >= c_BX_MAX - w_s) begin
                w_miss = 1'b1;
            end else begin
                w_bx_nxt = r_bx + w_s;
            end
        end
        if (w_miss) begin
            w_bx_nxt = c_BX0;
            w_by_nxt = c_BY0;
            w_dx_nxt = ~r_dx;
            w_dy_nxt = r_dy;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p1_y <= c_PAD_INIT;
            r_p2_y <= c_PAD_INIT;
            r_bx   <= c_BX0;
            r_by   <= c_BY0;
            r_dx   <= 1'b1;
            r_dy   <= 1'b1;
        end else if (w_tick && !sw[0]) begin
            r_p1_y <= paddle_next(r_p1_y, p1_up, p1_down);
            r_p2_y <= paddle_next(r_p2_y, p2_up, p2_down);
            r_bx   <= w_bx_nxt;
            r_by   <= w_by_nxt;
            r_dx   <= w_dx_nxt;
            r_dy   <= w_dy_nxt;
        end
    end

    assign w_vis     = (r_h < c_H_VIS) && (r_v < c_V_VIS);
    assign w_ball_px = (r_h >= r_bx) && (r_h < r_bx + c_BALL) &&
                       (r_v >= r_by) && (r_v < r_by + c_BALL);
    assign w_pad_px  = ((r_h >= c_P1_X) && (r_h < c_P1_X + c_PAD_W) &&
                        (r_v >= r_p1_y) && (r_v < r_p1_y + c_PAD_H)) ||
                       ((r_h >= c_P2_X) && (r_h < c_P2_X + c_PAD_W) &&
                        (r_v >= r_p2_y) && (r_v < r_p2_y + c_PAD_H));
    assign w_pix     = w_ball_px ? 3'b110 : (w_pad_px ? 3'b111 : 3'b000);
    assign w_rgb     = w_vis ? (w_pix ^ {3{sw[1]}}) : 3'b000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= 3'b000;
        end else begin
            r_hsync <= !((r_h >= c_HS_BEG) && (r_h <= c_HS_END));
            r_vsync <= !((r_v >= c_VS_BEG) && (r_v <= c_VS_END));
            r_rgb   <= w_rgb;
        end
    end

    assign hsync = r_hsync;
    assign vsync = r_vsync;
    assign rgb   = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_top_vga_pong.sv
`default_nettype none
// ============================================================================
// Module   : tb_top_vga_pong
// Purpose  : Randomised frame-level bench for top_vga_pong on a shrunk raster.
// Revision : 1.0
// ============================================================================
module tb_top_vga_pong;

    localparam int H_VIS = 64, H_FP = 2, H_SYNC = 4, H_BP = 2;
    localparam int V_VIS = 48, V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int PAD_H = 16, PAD_STEP = 4, BALL_SZ = 8;
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int N_FRAMES = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] sw = 3'b000;
    logic       p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
    logic       hsync, vsync;
    logic [2:0] rgb;

    top_vga_pong #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .PAD_H(PAD_H), .PAD_STEP(PAD_STEP), .BALL_SZ(BALL_SZ)
    ) u_dut (
        .clk(clk), .rst(rst), .sw(sw),
        .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
        .hsync(hsync), .vsync(vsync), .rgb(rgb)
    );

    always #20 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Game model: dx/dy are +1 (right/down) or -1.
    int m_p1, m_p2, m_bx, m_by, m_dx, m_dy;

    function automatic int pad_move(input int y, input logic up, input logic dn);
        if (up && !dn) return (y - PAD_STEP < 0) ? 0 : y - PAD_STEP;
        if (dn && !up) return (y + PAD_STEP > V_VIS - PAD_H) ? V_VIS - PAD_H : y + PAD_STEP;
        return y;
    endfunction

    task automatic model_tick(input logic [2:0] s_w, input logic u1, input logic d1,
                              input logic u2, input logic d2);
        int s, nbx, nby, ndx, ndy;
        bit miss;
        if (s_w[0]) return;
        s = s_w[2] ? 4 : 2;
        nbx = m_bx; nby = m_by; ndx = m_dx; ndy = m_dy; miss = 0;
        if (m_dy < 0) begin
            if (m_by <= s) begin nby = 0; ndy = 1; end
            else nby = m_by - s;
        end else begin
            if (m_by >= V_VIS - BALL_SZ - s) begin nby = V_VIS - BALL_SZ; ndy = -1; end
            else nby = m_by + s;
        end
        if (m_dx < 0) begin
            if (m_bx <= 24 && m_bx >= 16 && m_by + BALL_SZ > m_p1 && m_by < m_p1 + PAD_H) begin
                nbx = 24; ndx = 1;
            end else if (m_bx <= s) miss = 1;
            else nbx = m_bx - s;
        end else begin
            if (m_bx + BALL_SZ >= H_VIS - 24 && m_bx + BALL_SZ <= H_VIS - 16 &&
                m_by + BALL_SZ > m_p2 && m_by < m_p2 + PAD_H) begin
                nbx = H_VIS - 24 - BALL_SZ; ndx = -1;
            end else if (m_bx >= H_VIS - BALL_SZ - s) miss = 1;
            else nbx = m_bx + s;
        end
        if (miss) begin
            nbx = H_VIS / 2 - BALL_SZ / 2; nby = V_VIS / 2 - BALL_SZ / 2;
            ndx = -m_dx; ndy = m_dy;
        end
        m_p1 = pad_move(m_p1, u1, d1);
        m_p2 = pad_move(m_p2, u2, d2);
        m_bx = nbx; m_by = nby; m_dx = ndx; m_dy = ndy;
    endtask

    function automatic logic [2:0] exp_pix(input int h, input int v, input logic inv);
        bit ball, pad;
        logic [2:0] c;
        if (h >= H_VIS || v >= V_VIS) return 3'b000;
        ball = h >= m_bx && h < m_bx + BALL_SZ && v >= m_by && v < m_by + BALL_SZ;
        pad  = (h >= 16 && h < 24 && v >= m_p1 && v < m_p1 + PAD_H) ||
               (h >= H_VIS - 24 && h < H_VIS - 16 && v >= m_p2 && v < m_p2 + PAD_H);
        c = ball ? 3'b110 : (pad ? 3'b111 : 3'b000);
        return inv ? ~c : c;
    endfunction

    task automatic pick_inputs(input int f);
        sw[0] = ($urandom_range(0, 4) == 0);
        sw[1] = 1'($urandom_range(0, 1));
        sw[2] = 1'($urandom_range(0, 1));
        if (f < 6) begin
            p1_up = 1'b1; p1_down = (f == 5); p2_up = 1'b0; p2_down = 1'b1;
        end else if (f < 12) begin
            p1_up = 1'b0; p1_down = 1'b1; p2_up = 1'b1; p2_down = 1'b0;
        end else begin
            {p1_up, p1_down, p2_up, p2_down} = 4'($urandom_range(0, 15));
        end
    endtask

    // Per-frame accumulators and snapshot of the state being drawn.
    int hs_bad, vs_bad, rgb_bad, ball_x, ball_y, pad1_y;
    int s_bx, s_by, s_p1;
    logic s_inv;

    task automatic frame_begin();
        hs_bad = 0; vs_bad = 0; rgb_bad = 0;
        ball_x = 9999; ball_y = 9999; pad1_y = 9999;
        s_bx = m_bx; s_by = m_by; s_p1 = m_p1; s_inv = sw[1];
    endtask

    task automatic frame_end();
        chk("frame_hsync_errs", hs_bad, 0);
        chk("frame_vsync_errs", vs_bad, 0);
        chk("frame_rgb_errs", rgb_bad, 0);
        chk("ball_x", ball_x, s_bx);
        chk("ball_y", ball_y, s_by);
        if (!(s_bx <= 16 && s_bx + BALL_SZ > 16))
            chk("paddle1_top", pad1_y, s_p1);
    endtask

    initial begin
        int h, v, p;
        int hs_f1, hs_f2, vs_f1, vs_f2;
        bit hs_w, vs_w;
        logic prev_hs, prev_vs;
        logic [2:0] e_rgb;

        m_p1 = (V_VIS - PAD_H) / 2; m_p2 = m_p1;
        m_bx = H_VIS / 2 - BALL_SZ / 2; m_by = V_VIS / 2 - BALL_SZ / 2;
        m_dx = 1; m_dy = 1;
        hs_f1 = -1; hs_f2 = -1; vs_f1 = -1; vs_f2 = -1; hs_w = 0; vs_w = 0;
        prev_hs = 1'b1; prev_vs = 1'b1;

        pick_inputs(0);
        repeat (10) @(posedge clk);
        #1;
        chk("reset_hsync", hsync, 1);
        chk("reset_vsync", vsync, 1);
        chk("reset_rgb", rgb, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int cyc = 1; cyc <= N_FRAMES * H_TOT * V_TOT; cyc++) begin
            @(posedge clk);
            #1;
            p = cyc - 1;
            h = p % H_TOT;
            v = (p / H_TOT) % V_TOT;
            if (h == 0 && v == 0) begin
                if (cyc > 1) frame_end();
                frame_begin();
            end
            if (hsync !== ((h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC) ? 1'b0 : 1'b1)) hs_bad++;
            if (vsync !== ((v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC) ? 1'b0 : 1'b1)) vs_bad++;
            e_rgb = exp_pix(h, v, sw[1]);
            if (rgb !== e_rgb) rgb_bad++;
            if (h < H_VIS && v < V_VIS) begin
                if (rgb === (s_inv ? 3'b001 : 3'b110)) begin
                    if (h < ball_x) ball_x = h;
                    if (v < ball_y) ball_y = v;
                end
                if (h == 16 && rgb === (s_inv ? 3'b000 : 3'b111) && v < pad1_y) pad1_y = v;
            end

            if (prev_hs === 1'b1 && hsync === 1'b0) begin
                if (hs_f1 < 0) begin
                    hs_f1 = cyc;
                    chk("hsync_first_fall", cyc, H_VIS + H_FP + 1);
                end else if (hs_f2 < 0) begin
                    hs_f2 = cyc;
                    chk("hsync_period", hs_f2 - hs_f1, H_TOT);
                end
            end
            if (prev_hs === 1'b0 && hsync === 1'b1 && !hs_w) begin
                hs_w = 1;
                chk("hsync_width", cyc - hs_f1, H_SYNC);
            end
            if (prev_vs === 1'b1 && vsync === 1'b0) begin
                if (vs_f1 < 0) begin
                    vs_f1 = cyc;
                    chk("vsync_first_fall", cyc, (V_VIS + V_FP) * H_TOT + 1);
                end else if (vs_f2 < 0) begin
                    vs_f2 = cyc;
                    chk("vsync_period", vs_f2 - vs_f1, H_TOT * V_TOT);
                end
            end
            if (prev_vs === 1'b0 && vsync === 1'b1 && !vs_w) begin
                vs_w = 1;
                chk("vsync_width", cyc - vs_f1, V_SYNC * H_TOT);
            end
            prev_hs = hsync;
            prev_vs = vsync;

            // The DUT applies the frame tick on the edge that leaves this position.
            if (h == 0 && v == V_VIS)
                model_tick(sw, p1_up, p1_down, p2_up, p2_down);
            if (h == 0 && v == V_VIS + 1)
                pick_inputs(p / (H_TOT * V_TOT) + 1);
        end
        frame_end();
        if (!hs_w) chk("hsync_seen", 0, 1);
        if (!vs_w) chk("vsync_seen", 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/top_vga_pong.md
Name: top_vga_pong

Overview:
- Top-level two-player "pong" video block with 640x480@60 VGA timing, one pixel per clock.
- Generates hsync/vsync and 3-bit RGB.
- Holds two paddle positions, each driven by an up/down button pair, and one bouncing ball.
- Slide switches select pause, colour inversion and ball speed.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch; line total 800
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch; frame total 525
- PAD_H, 80, paddle height (px); paddle width fixed at 8
- PAD_STEP, 4, paddle movement per frame (px)
- BALL_SZ, 8, ball side length (px)

Ports:
- clk  in  1  pixel clock (25 MHz nominal); all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- sw  in  3  sw[0]=pause, sw[1]=invert colours, sw[2]=fast ball
- p1_up  in  1  left paddle up, active-high level
- p1_down  in  1  left paddle down, active-high level
- p2_up  in  1  right paddle up, active-high level
- p2_down  in  1  right paddle down, active-high level
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- rgb  out  3  {r,g,b} colour, 1 bit each

Behaviour:
Interface
- One clock, clk.
- Reset rst is asynchronous and active-low.
- Inputs are assumed synchronous to clk; no debouncing.

Timing generator
- h_cnt counts 0..799 and wraps to 0.
- v_cnt increments when h_cnt wraps; counts 0..524 and wraps to 0.
- Sync levels (before output register):
  - hsync=0 iff h_cnt in 656..751.
  - vsync=0 iff v_cnt in 490..491.
- visible = h_cnt<640 and v_cnt<480.
- All outputs are registered. hsync, vsync and rgb at cycle n+1 reflect counters at cycle n, so all three have 1-clock latency and stay mutually aligned.

Reset (rst=0)
- h_cnt=0, v_cnt=0.
- hsync=1, vsync=1, rgb=000.
- Paddle tops p1_y=p2_y=200.
- Ball at (316,236), dx=+1 (right), dy=+1 (down).

Frame tick
- One-cycle pulse when h_cnt==0 and v_cnt==480.
- All game state updates only on tick. If sw[0]=1 on a tick, no state changes.

Paddles (per tick)
- up only: y = max(y-PAD_STEP, 0).
- down only: y = min(y+PAD_STEP, 480-PAD_H) = 400.
- both or neither pressed: no change.
- Left paddle x 16..23; right paddle x 616..623.

Ball (per tick)
- Speed s = 4 if sw[2] else 2 px per axis.
- Vertical:
  - If moving up and by<=s: by=0 and dy becomes down.
  - If moving down and by>=472-s: by=472 and dy becomes up.
  - Otherwise by += ±s.
- Horizontal, left side, moving left:
  - If bx<=24 and bx>=16 and the ball overlaps p1 vertically (by+8>p1_y and by<p1_y+PAD_H): bx=24, dx becomes right.
  - Else if bx<=s: miss.
- Horizontal, right side (mirror of left), moving right:
  - Paddle hit if bx+8>=616 and bx+8<=624 with vertical overlap on p2: bx=608.
  - Else if bx>=632-s: miss.
- Miss: ball returns to (316,236), dx reversed, dy unchanged.
- Paddle updates and ball update use pre-tick paddle positions.

Pixel colour (pre-register)
- Not visible: 000.
- Ball pixel: 110.
- Paddle pixel: 111.
- Otherwise background: 000.
- Priority: ball > paddle > background.
- If sw[1]=1, visible pixels are bitwise inverted. Blanking stays 000.

Test Plan:
- Reset: hold rst=0 for 10 clks -> hsync=1, vsync=1, rgb=000. After release, first hsync falling edge appears 657 clks after release; low for exactly 96 clks; period 800 clks.
- Frame timing: run 2 frames -> vsync low for exactly 1600 clks (2 lines); vsync period 420000 clks; rgb=000 whenever h_cnt>=640 or v_cnt>=480.
- Paddle motion: hold p1_up for 10 ticks -> p1_y=160, left paddle drawn 111 at x=16..23, y=160..239. Hold 100 ticks -> clamps at 0. Hold p1_down 200 ticks -> clamps at 400. p1_up=p1_down=1 -> no move.
- Pause/speed: sw=001 for 5 ticks -> ball and paddles unchanged. sw=100 from reset -> after 1 tick ball at (320,240). sw=000 from reset -> ball at (318,238).
- Bounce/miss: paddles idle at y=200; ball reaches right paddle region with overlap -> dx flips, bx=608. Move p2 to y=0, let ball pass -> ball resets to (316,236) with dx reversed. Top edge contact -> dy flips, by=0.
- Invert: sw=010 -> background pixel rgb=111, paddle=000, ball=001; blanking still 000.
